// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and defaults for the word-serial CLA adder sequencer.
package cla_seq_adder_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

  localparam int CLA_WIDTH = 4;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand request and result channels of the sequencer, both valid/ready.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
);
  localparam int N = WIDTH * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla.sv
// Purely combinational WIDTH-bit carry-lookahead adder slice.
module carry_lookahead_adder
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum of generate terms ANDed with all propagates above them.
  always_comb begin
    logic ci;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      ci = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        ci = ci | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = ci | (pp & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Adds two WORDS*WIDTH-bit operands on one WIDTH-bit CLA slice, LSW first,
// one word per clock with the carry registered between beats.
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_seq_adder_ctrl_if.slave  bus
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  cla_seq_state_t  state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [N-1:0]    sum_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;

  logic [WIDTH-1:0] sl_a;
  logic [WIDTH-1:0] sl_b;
  logic [WIDTH-1:0] sl_sum;
  logic             sl_cout;

  assign sl_a = a_reg[int'(idx)*WIDTH +: WIDTH];
  assign sl_b = b_reg[int'(idx)*WIDTH +: WIDTH];

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.in_a;
            b_reg        <= bus.in_b;
            carry        <= bus.in_cin;
            idx          <= '0;
            state        <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg[int'(idx)*WIDTH +: WIDTH] <= sl_sum;
          carry                             <= sl_cout;
          if (idx == LAST_IDX) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
            cout_reg      <= sl_cout;
            // Top slice sum bit is the result sign bit.
            ovf_reg       <= (a_reg[N-1] == b_reg[N-1]) && (sl_sum[WIDTH-1] != a_reg[N-1]);
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
  assign bus.out_ovf   = ovf_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed and random checks of the sequencer at WORDS=4 and WORDS=1.
module tb_cla_seq_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl_if #(.WIDTH(4), .WORDS(4)) if4 ();
  cla_seq_adder_ctrl_if #(.WIDTH(4), .WORDS(1)) if1 ();

  cla_seq_adder_ctrl #(.WIDTH(4), .WORDS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  cla_seq_adder_ctrl #(.WIDTH(4), .WORDS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Issue one op on the 16-bit unit and wait for its result; optionally scramble inputs mid-op.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input bit scramble, output int lat);
    if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if (scramble) begin
      if4.in_a = ~a; if4.in_b = ~b; if4.in_cin = ~cin;
    end
    lat = 0;
    while (!if4.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (if4.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL op4_timeout: out_valid=%b after %0d cycles, want 1", if4.out_valid, lat);
    end
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin, output int lat);
    if1.in_a = a; if1.in_b = b; if1.in_cin = cin; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 0;
    while (!if1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (if1.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL op1_timeout: out_valid=%b after %0d cycles, want 1", if1.out_valid, lat);
    end
  endtask

  task automatic retire4();
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
  endtask

  task automatic retire1();
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.in_valid = 0; if4.in_a = 0; if4.in_b = 0; if4.in_cin = 0; if4.out_ready = 0;
    if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.in_cin = 0; if1.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({if4.in_ready, if4.out_valid, if4.busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_ctrl4: {in_ready,out_valid,busy}=%b want 100",
               {if4.in_ready, if4.out_valid, if4.busy});
    end
    tests++;
    if ({if4.out_cout, if4.out_ovf, if4.out_sum} !== 18'h0) begin
      fails++;
      $display("FAIL reset_data4: cout=%b ovf=%b sum=%h want 0 0 0000",
               if4.out_cout, if4.out_ovf, if4.out_sum);
    end
    tests++;
    if ({if1.in_ready, if1.out_valid, if1.busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_ctrl1: {in_ready,out_valid,busy}=%b want 100",
               {if1.in_ready, if1.out_valid, if1.busy});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles want 4", lat);
    end
    tests++;
    if ({if4.out_cout, if4.out_ovf, if4.out_sum} !== {1'b1, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL basic_ffff: cout=%b ovf=%b sum=%h want 1 0 0000", if4.out_cout, if4.out_ovf, if4.out_sum);
    end
    retire4();
    tests++;
    if ({if4.in_ready, if4.out_valid, if4.busy} !== 3'b100) begin
      fails++;
      $display("FAIL basic_retire: {in_ready,out_valid,busy}=%b want 100",
               {if4.in_ready, if4.out_valid, if4.busy});
    end
    op4(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    tests++;
    if ({if4.out_cout, if4.out_ovf, if4.out_sum} !== {1'b0, 1'b0, 16'h5556}) begin
      fails++;
      $display("FAIL basic_1234: cout=%b ovf=%b sum=%h want 0 0 5556", if4.out_cout, if4.out_ovf, if4.out_sum);
    end
    retire4();
    op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    tests++;
    if ({if4.out_cout, if4.out_ovf, if4.out_sum} !== {1'b0, 1'b1, 16'h8000}) begin
      fails++;
      $display("FAIL basic_7fff: cout=%b ovf=%b sum=%h want 0 1 8000", if4.out_cout, if4.out_ovf, if4.out_sum);
    end
    retire4();
  endtask

  task automatic test_backpressure();
    int lat;
    op4(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        if4.in_a = 16'h1111; if4.in_b = 16'h2222; if4.in_cin = 1'b0; if4.in_valid = 1'b1;
      end else begin
        if4.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      tests++;
      if ({if4.out_valid, if4.in_ready, if4.busy, if4.out_cout, if4.out_ovf, if4.out_sum} !==
          {5'b10110, 16'h0000}) begin
        fails++;
        $display("FAIL stall_cycle%0d: valid=%b in_ready=%b busy=%b cout=%b ovf=%b sum=%h want 1 0 1 1 0 0000",
                 i, if4.out_valid, if4.in_ready, if4.busy, if4.out_cout, if4.out_ovf, if4.out_sum);
      end
    end
    if4.in_valid = 1'b0;
    retire4();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({if4.in_ready, if4.out_valid, if4.busy} !== 3'b100) begin
      fails++;
      $display("FAIL stall_ignored_input: {in_ready,out_valid,busy}=%b want 100",
               {if4.in_ready, if4.out_valid, if4.busy});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    if4.in_a = 16'hFFFF; if4.in_b = 16'h0001; if4.in_cin = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({if4.out_valid, if4.in_ready, if4.busy} !== 3'b010 || if4.out_sum !== 16'h0) begin
      fails++;
      $display("FAIL midrun_reset: valid=%b in_ready=%b busy=%b sum=%h want 0 1 0 0000",
               if4.out_valid, if4.in_ready, if4.busy, if4.out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op4(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    tests++;
    if ({if4.out_cout, if4.out_sum} !== {1'b0, 16'h1000} || lat !== 4) begin
      fails++;
      $display("FAIL after_reset_op: cout=%b sum=%h lat=%0d want 0 1000 4", if4.out_cout, if4.out_sum, lat);
    end
    retire4();
  endtask

  task automatic test_change_inputs();
    int lat;
    op4(16'h1111, 16'h2222, 1'b0, 1'b1, lat);
    tests++;
    if ({if4.out_cout, if4.out_ovf, if4.out_sum} !== {1'b0, 1'b0, 16'h3333}) begin
      fails++;
      $display("FAIL latched_operands: cout=%b ovf=%b sum=%h want 0 0 3333", if4.out_cout, if4.out_ovf, if4.out_sum);
    end
    if4.in_a = 16'h0; if4.in_b = 16'h0; if4.in_cin = 1'b0;
    retire4();
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [15:0] a, b;
    logic        cin;
    logic [16:0] exp;
    logic        exp_ovf;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      exp     = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      exp_ovf = (a[15] == b[15]) && (exp[15] != a[15]);
      op4(a, b, cin, 1'($urandom), lat);
      tests++;
      if ({if4.out_cout, if4.out_sum} !== exp || if4.out_ovf !== exp_ovf || lat !== 4) begin
        fails++;
        $display("FAIL rand4 #%0d %h+%h+%b: cout=%b sum=%h ovf=%b lat=%0d want %b %h %b 4",
                 n, a, b, cin, if4.out_cout, if4.out_sum, if4.out_ovf, lat, exp[16], exp[15:0], exp_ovf);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      retire4();
    end
  endtask

  task automatic test_words1();
    int         lat;
    logic [3:0] a, b;
    logic       cin;
    logic [4:0] exp;
    logic       exp_ovf;
    op1(4'hF, 4'h1, 1'b0, lat);
    tests++;
    if ({if1.out_cout, if1.out_ovf, if1.out_sum} !== {1'b1, 1'b0, 4'h0} || lat !== 1) begin
      fails++;
      $display("FAIL w1_f_plus_1: cout=%b ovf=%b sum=%h lat=%0d want 1 0 0 1", if1.out_cout, if1.out_ovf, if1.out_sum, lat);
    end
    retire1();
    op1(4'h7, 4'h1, 1'b0, lat);
    tests++;
    if ({if1.out_cout, if1.out_ovf, if1.out_sum} !== {1'b0, 1'b1, 4'h8}) begin
      fails++;
      $display("FAIL w1_7_plus_1: cout=%b ovf=%b sum=%h want 0 1 8", if1.out_cout, if1.out_ovf, if1.out_sum);
    end
    retire1();
    for (int n = 0; n < 300; n++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      exp     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      exp_ovf = (a[3] == b[3]) && (exp[3] != a[3]);
      op1(a, b, cin, lat);
      tests++;
      if ({if1.out_cout, if1.out_sum} !== exp || if1.out_ovf !== exp_ovf || lat !== 1) begin
        fails++;
        $display("FAIL rand1 #%0d %h+%h+%b: cout=%b sum=%h ovf=%b lat=%0d want %b %h %b 1",
                 n, a, b, cin, if1.out_cout, if1.out_sum, if1.out_ovf, lat, exp[4], exp[3:0], exp_ovf);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      retire1();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_change_inputs();
    test_back_to_back();
    test_words1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
